// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and framing constants
package uart_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_DIV_MIN = 2;
endpackage

// File: rtl/fifo.sv
// fifo: synchronous first-word-fall-through FIFO, dout shows the head entry
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic w_wr, w_rd;
  assign w_wr = push & ~full;
  assign w_rd = pop & ~empty;
  assign empty = r_wp == r_rp;
  assign full = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign dout = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp[AW-1:0]] <= din;
  always_ff @(posedge clk)
    if (!resetn) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
    end
endmodule

// File: rtl/rx_uart.sv
// rx_uart: 8N1 oversampling UART receiver feeding a byte FIFO.
// Define RX_UART_MAJORITY_EN for 2-of-3 majority sampling (divisor clamped to 4).
module rx_uart
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_in,
  input  logic [15:0] div,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic        err_clr,
  output logic        overrun,
  output logic        frame_err,
  output logic        busy
);
`ifdef RX_UART_MAJORITY_EN
  localparam logic [16:0] DMIN = 17'd4;
  localparam logic [16:0] RL = 17'd2;
`else
  localparam logic [16:0] DMIN = 17'(UART_DIV_MIN);
  localparam logic [16:0] RL = 17'd1;
`endif
  state_t r_state;
  logic r_m1, r_s, r_ovr, r_fe;
  logic [16:0] r_cnt, r_d, w_d;
  logic [7:0] r_sh;
  logic [2:0] r_idx;
  logic w_tick, w_bit, w_full, w_empty, w_stop, w_push;
  assign w_d = ({1'b0, div} < DMIN) ? DMIN : {1'b0, div};
`ifdef RX_UART_MAJORITY_EN
  logic r_s1, r_s0, r_ph;
  assign w_tick = r_ph;
  assign w_bit = (r_s1 & r_s0) | (r_s1 & r_s) | (r_s0 & r_s);
  // r_s1 also tracks the line while idle so a short first half-bit still has a valid vote
  always_ff @(posedge clk)
    if (!resetn) begin
      r_s1 <= 1'b1;
      r_s0 <= 1'b1;
      r_ph <= 1'b0;
    end else begin
      if (r_cnt == 17'd1 || r_state == S_IDLE) r_s1 <= r_s;
      if (r_cnt == 17'd0) r_s0 <= r_s;
      r_ph <= r_cnt == 17'd0 && !r_ph && r_state inside {S_START, S_DATA, S_STOP};
    end
`else
  assign w_tick = r_cnt == 17'd0;
  assign w_bit = r_s;
`endif
  assign w_stop = r_state == S_STOP && w_tick;
  assign w_push = w_stop & w_bit & ~w_full;
  assign busy = r_state != S_IDLE;
  assign rx_valid = ~w_empty;
  assign overrun = r_ovr;
  assign frame_err = r_fe;
  always_ff @(posedge clk)
    if (!resetn) begin
      r_m1 <= 1'b1;
      r_s <= 1'b1;
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_d <= '0;
      r_sh <= '0;
      r_idx <= '0;
      r_ovr <= 1'b0;
      r_fe <= 1'b0;
    end else begin
      r_m1 <= rx_in;
      r_s <= r_m1;
      r_ovr <= (w_stop & w_bit & w_full) | (r_ovr & ~err_clr);
      r_fe <= (w_stop & ~w_bit) | (r_fe & ~err_clr);
      if (r_state inside {S_START, S_DATA, S_STOP} && !w_tick && r_cnt != 17'd0) r_cnt <= r_cnt - 17'd1;
      case (r_state)
        S_IDLE:
          if (!r_s) begin
            r_d <= w_d;
            r_cnt <= (w_d >> 1) - RL;
            r_state <= S_START;
          end
        S_START:
          if (w_tick) begin
            r_cnt <= r_d - RL;
            r_idx <= '0;
            r_state <= w_bit ? S_IDLE : S_DATA;
          end
        S_DATA:
          if (w_tick) begin
            r_sh <= {w_bit, r_sh[7:1]};
            r_cnt <= r_d - RL;
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'(UART_DATA_BITS - 1)) r_state <= S_STOP;
          end
        S_STOP: if (w_tick) r_state <= w_bit ? S_IDLE : S_BREAK;
        S_BREAK: if (r_s) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  fifo #(.DATA_WIDTH(8), .DEPTH(FIFO_DEPTH)) rx_fifo_i (
    .clk(clk),
    .resetn(resetn),
    .push(w_push),
    .din(r_sh),
    .pop(rx_valid & rx_ready),
    .dout(rx_data),
    .full(w_full),
    .empty(w_empty)
  );
endmodule

// File: tb/tb_rx_uart.sv
// tb_rx_uart: randomized and directed checks of rx_uart against a frame-level model
module tb_rx_uart;
  localparam int DEPTH = 4;
`ifdef RX_UART_MAJORITY_EN
  localparam int DMIN = 4;
`else
  localparam int DMIN = 2;
`endif
  logic clk = 0, resetn = 0, rx_in = 1, rx_ready = 0, err_clr = 0;
  logic [15:0] div = 16'd16;
  logic [7:0] rx_data;
  logic rx_valid, overrun, frame_err, busy;
  int n_chk = 0, n_err = 0, cyc = 0, last_start = 0;
  bit rnd_rdy = 0;
  logic [7:0] got[$], exp_q[$];
  int pop_cyc[$];

  rx_uart #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .rx_in(rx_in), .div(div), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .err_clr(err_clr),
    .overrun(overrun), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (resetn && rx_valid && rx_ready) begin
      got.push_back(rx_data);
      pop_cyc.push_back(cyc);
    end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_rdy) rx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic int eff(input int dv);
    return dv < DMIN ? DMIN : dv;
  endfunction

  task automatic send(input logic [7:0] b, input int dv, input int low_stop = 0);
    int d;
    d = eff(dv);
    div = 16'(dv);
    rx_in = 0;
    last_start = cyc;
    tick(d);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(d);
    end
    if (low_stop > 0) begin
      rx_in = 0;
      tick(low_stop * d);
      check("brk_busy", busy, 1);
      check("brk_frame_err", frame_err, 1);
    end
    rx_in = 1;
    tick(d);
  endtask

  task automatic drain(input string tag);
    rnd_rdy = 0;
    rx_ready = 1;
    for (int k = 0; k < 400 && (got.size() < exp_q.size() || rx_valid); k++) tick;
    tick(2);
    check({tag, "_count"}, got.size(), exp_q.size());
    foreach (exp_q[i]) check({tag, "_data"}, i < got.size() ? {24'd0, got[i]} : 32'hffffffff, {24'd0, exp_q[i]});
    check({tag, "_valid_low"}, rx_valid, 0);
    got.delete();
    exp_q.delete();
    pop_cyc.delete();
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int s1, s2, k, occ, dv, d;
    logic exp_ovr;
    logic [7:0] b;
    tick(5);
    check("rst_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    resetn = 1;
    tick(3);
    rx_ready = 1;
    send(8'h55, 16);
    s1 = last_start;
    send(8'hA3, 16);
    s2 = last_start;
    exp_q = '{8'h55, 8'hA3};
    tick(5);
    check("lat0", pop_cyc.size() > 0 ? pop_cyc[0] - s1 : -1, 3 + 16 / 2 + 9 * 16);
    check("lat1", pop_cyc.size() > 1 ? pop_cyc[1] - s2 : -1, 3 + 16 / 2 + 9 * 16);
    check("b2b_overrun", overrun, 0);
    check("b2b_frame_err", frame_err, 0);
    drain("b2b");
    rx_in = 0;
    tick(5);
    rx_in = 1;
    check("glitch_busy", busy, 1);
    k = 0;
    while (k < 30 && busy) begin
      tick;
      k++;
    end
    check("glitch_time", k, 6);
    check("glitch_frame_err", frame_err, 0);
    check("glitch_overrun", overrun, 0);
    check("glitch_valid", rx_valid, 0);
    send(8'h7E, 16, 3);
    check("brk_exit_busy", busy, 0);
    send(8'h41, 16);
    exp_q.push_back(8'h41);
    check("fe_sticky", frame_err, 1);
    drain("fe");
    err_clr = 1;
    tick;
    err_clr = 0;
    check("fe_cleared", frame_err, 0);
    rx_ready = 0;
    occ = 0;
    exp_ovr = 0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 16);
      if (occ < DEPTH) begin
        exp_q.push_back(8'(i));
        occ++;
      end else exp_ovr = 1;
    end
    check("ovr_flag", overrun, 32'(exp_ovr));
    check("ovr_valid", rx_valid, 1);
    drain("ovr");
    err_clr = 1;
    tick;
    err_clr = 0;
    check("ovr_cleared", overrun, 0);
    send(8'hC3, 0);
    exp_q.push_back(8'hC3);
    drain("div0");
    div = 16'd16;
    rx_in = 0;
    tick(16);
    rx_in = 1;
    tick(24);
    check("rst_mid_busy", busy, 1);
    resetn = 0;
    tick(3);
    check("rst_mid_idle", busy, 0);
    resetn = 1;
    tick(32);
    send(8'h12, 16);
    exp_q.push_back(8'h12);
    drain("rst_mid");
    check("rst_mid_overrun", overrun, 0);
    check("rst_mid_frame_err", frame_err, 0);
    rnd_rdy = 1;
    for (int i = 0; i < 24; i++) begin
      dv = $urandom_range(0, 20);
      d = eff(dv);
      b = 8'($urandom);
      div = 16'(dv);
      if ($urandom_range(0, 3) == 0) begin
        rx_in = 0;
        tick;
        rx_in = 1;
        tick(d + 6);
      end
      send(b, dv);
      exp_q.push_back(b);
      tick($urandom_range(0, d));
    end
    drain("rnd");
    check("rnd_overrun", overrun, 0);
    check("rnd_frame_err", frame_err, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
